// File: rtl/m_2s_complement_seq.sv
// Sequential negate/abs/ones'-complement unit for the Booth datapath: operand is
// optionally inverted, then the +1 ripples through CHUNK-bit slices, one per cycle.
module m_2s_complement_seq #(
  parameter int BITLEN = 8,
  parameter int CHUNK  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [BITLEN-1:0] in_tog,
  input  logic [1:0]        in_mode,
  input  logic              in_tog_valid_pulse,
  output logic              mod_busy,
  output logic [BITLEN-1:0] out_tog,
  output logic              out_ovf,
  output logic              out_tog_valid_pulse,
  output logic              out_drop_pulse
);

  localparam int NCH   = BITLEN / CHUNK;
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_NEG  = 2'b01;
  localparam logic [1:0] MODE_ABS  = 2'b10;
  localparam logic [1:0] MODE_ONES = 2'b11;

  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NCH - 1);
  localparam logic [BITLEN-1:0] MOST_NEG = {1'b1, {(BITLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_WAIT = 2'b00,
    ST_LOAD = 2'b01,
    ST_ADD  = 2'b10,
    ST_FIN  = 2'b11
  } state_t;

  state_t state, state_nxt;

  logic signed [BITLEN-1:0] op_r, op_nxt;
  logic [1:0]               mode_r, mode_nxt;
  logic [BITLEN-1:0]        work_r, work_nxt;
  logic                     carry_r, carry_nxt;
  logic [IDX_W-1:0]         idx_r, idx_nxt;
  logic                     ovf_r, ovf_nxt;

  logic                     busy_nxt;
  logic [BITLEN-1:0]        out_tog_nxt;
  logic                     out_ovf_nxt;
  logic                     vld_nxt;
  logic                     drop_nxt;

  logic [CHUNK-1:0]         chunk_cur;
  logic [CHUNK:0]           chunk_sum;
  logic [BITLEN-1:0]        work_add;

  // Increment one slice; the MSB of the result is the slice carry-out.
  function automatic logic [CHUNK:0] chunk_inc(input logic [CHUNK-1:0] c,
                                               input logic cin);
    return {1'b0, c} + {{CHUNK{1'b0}}, cin};
  endfunction

  function automatic logic needs_invert(input logic [1:0] mode, input logic msb);
    return (mode == MODE_NEG) || (mode == MODE_ONES) || ((mode == MODE_ABS) && msb);
  endfunction

  function automatic logic needs_carry(input logic [1:0] mode, input logic msb);
    return (mode == MODE_NEG) || ((mode == MODE_ABS) && msb);
  endfunction

  // Only the most-negative value has no representable negation.
  function automatic logic is_ovf(input logic [1:0] mode, input logic [BITLEN-1:0] op);
    return ((mode == MODE_NEG) || (mode == MODE_ABS)) && (op == MOST_NEG);
  endfunction

  always_comb begin
    chunk_cur = '0;
    for (int i = 0; i < NCH; i++) begin
      if (idx_r == IDX_W'(i)) chunk_cur = work_r[i*CHUNK +: CHUNK];
    end
    chunk_sum = chunk_inc(chunk_cur, carry_r);
    work_add  = work_r;
    for (int i = 0; i < NCH; i++) begin
      if (idx_r == IDX_W'(i)) work_add[i*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
    end
  end

  always_comb begin
    state_nxt   = state;
    op_nxt      = op_r;
    mode_nxt    = mode_r;
    work_nxt    = work_r;
    carry_nxt   = carry_r;
    idx_nxt     = idx_r;
    ovf_nxt     = ovf_r;
    busy_nxt    = mod_busy;
    out_tog_nxt = out_tog;
    out_ovf_nxt = out_ovf;
    vld_nxt     = 1'b0;
    drop_nxt    = in_tog_valid_pulse && (state != ST_WAIT);

    case (state)
      ST_WAIT: begin
        if (in_tog_valid_pulse) begin
          op_nxt    = in_tog;
          mode_nxt  = in_mode;
          busy_nxt  = 1'b1;
          state_nxt = ST_LOAD;
        end
      end
      // Stage: conditional inversion and carry-in selection
      ST_LOAD: begin
        work_nxt  = needs_invert(mode_r, op_r[BITLEN-1]) ? ~op_r : op_r;
        carry_nxt = needs_carry(mode_r, op_r[BITLEN-1]);
        ovf_nxt   = is_ovf(mode_r, op_r);
        idx_nxt   = '0;
        state_nxt = ST_ADD;
      end
      // Stage: carry ripple, fixed NCH cycles; final carry-out is dropped
      ST_ADD: begin
        work_nxt  = work_add;
        carry_nxt = chunk_sum[CHUNK];
        if (idx_r == IDX_LAST) begin
          state_nxt = ST_FIN;
        end else begin
          idx_nxt = idx_r + 1'b1;
        end
      end
      // Stage: publish result
      ST_FIN: begin
        out_tog_nxt = work_r;
        out_ovf_nxt = ovf_r;
        vld_nxt     = 1'b1;
        busy_nxt    = 1'b0;
        state_nxt   = ST_WAIT;
      end
      default: state_nxt = ST_WAIT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state               <= ST_WAIT;
      op_r                <= '0;
      mode_r              <= '0;
      work_r              <= '0;
      carry_r             <= 1'b0;
      idx_r               <= '0;
      ovf_r               <= 1'b0;
      mod_busy            <= 1'b0;
      out_tog             <= '0;
      out_ovf             <= 1'b0;
      out_tog_valid_pulse <= 1'b0;
      out_drop_pulse      <= 1'b0;
    end else begin
      state               <= state_nxt;
      op_r                <= op_nxt;
      mode_r              <= mode_nxt;
      work_r              <= work_nxt;
      carry_r             <= carry_nxt;
      idx_r               <= idx_nxt;
      ovf_r               <= ovf_nxt;
      mod_busy            <= busy_nxt;
      out_tog             <= out_tog_nxt;
      out_ovf             <= out_ovf_nxt;
      out_tog_valid_pulse <= vld_nxt;
      out_drop_pulse      <= drop_nxt;
    end
  end

endmodule

// File: tb/tb_m_2s_complement_seq.sv
// Bench for m_2s_complement_seq (BITLEN=8, CHUNK=4): directed corner cases plus
// randomized operations against an arithmetic reference model.
module tb_m_2s_complement_seq;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_tog = '0;
  logic [1:0] in_mode = '0;
  logic       in_tog_valid_pulse = 1'b0;
  logic       mod_busy;
  logic [7:0] out_tog;
  logic       out_ovf;
  logic       out_tog_valid_pulse;
  logic       out_drop_pulse;

  int checks = 0;
  int errors = 0;
  logic [7:0] last_out = '0;
  logic       last_ovf = 1'b0;

  m_2s_complement_seq #(.BITLEN(8), .CHUNK(4)) dut (
    .clock(clock),
    .reset(reset),
    .in_tog(in_tog),
    .in_mode(in_mode),
    .in_tog_valid_pulse(in_tog_valid_pulse),
    .mod_busy(mod_busy),
    .out_tog(out_tog),
    .out_ovf(out_ovf),
    .out_tog_valid_pulse(out_tog_valid_pulse),
    .out_drop_pulse(out_drop_pulse)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: {ovf, result} from plain integer arithmetic modulo 256.
  function automatic logic [8:0] ref_model(input logic [1:0] mode, input logic [7:0] op);
    int v, r;
    logic o;
    v = op;
    case (mode)
      2'd0:    r = v;
      2'd1:    r = (256 - v) % 256;
      2'd2:    r = (v >= 128) ? (256 - v) % 256 : v;
      default: r = 255 - v;
    endcase
    o = ((mode == 2'd1) || (mode == 2'd2)) && (v == 128);
    return {o, 8'(r)};
  endfunction

  task automatic run_op(input logic [1:0] mode, input logic [7:0] op);
    logic [8:0] exp;
    exp = ref_model(mode, op);
    @(negedge clock);
    in_tog = op; in_mode = mode; in_tog_valid_pulse = 1'b1;
    @(posedge clock);
    #1 in_tog_valid_pulse = 1'b0;
    chk("busy_after_accept", mod_busy, 1);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clock);
      #1;
      chk("no_early_valid", out_tog_valid_pulse, 0);
      chk("out_hold", out_tog, last_out);
    end
    @(posedge clock);
    #1;
    chk("valid_pulse", out_tog_valid_pulse, 1);
    chk("result", out_tog, exp[7:0]);
    chk("ovf", out_ovf, exp[8]);
    chk("busy_clear", mod_busy, 0);
    last_out = exp[7:0];
    last_ovf = exp[8];
  endtask

  initial begin
    int vcnt;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_out_tog", out_tog, 0);
    chk("rst_ovf", out_ovf, 0);
    chk("rst_busy", mod_busy, 0);
    chk("rst_valid", out_tog_valid_pulse, 0);
    chk("rst_drop", out_drop_pulse, 0);
    @(negedge clock) reset = 1'b0;

    run_op(2'b01, 8'h05);
    run_op(2'b01, 8'h80);
    run_op(2'b10, 8'h80);
    run_op(2'b01, 8'h00);
    run_op(2'b10, 8'hF0);
    run_op(2'b10, 8'h10);
    run_op(2'b00, 8'h7F);
    run_op(2'b11, 8'h5A);
    run_op(2'b01, 8'h10);
    run_op(2'b01, 8'h01);

    // Busy requests: one two cycles after accept, one in the FIN cycle.
    @(negedge clock);
    in_tog = 8'h22; in_mode = 2'b01; in_tog_valid_pulse = 1'b1;
    @(posedge clock);
    #1 in_tog_valid_pulse = 1'b0;
    @(posedge clock);
    @(negedge clock);
    in_tog = 8'h99; in_mode = 2'b00; in_tog_valid_pulse = 1'b1;
    @(posedge clock);
    #1 in_tog_valid_pulse = 1'b0;
    chk("drop_pulse", out_drop_pulse, 1);
    @(posedge clock);
    #1;
    chk("drop_one_cycle", out_drop_pulse, 0);
    @(negedge clock);
    in_tog = 8'h33; in_mode = 2'b00; in_tog_valid_pulse = 1'b1;
    @(posedge clock);
    #1 in_tog_valid_pulse = 1'b0;
    chk("drop_valid", out_tog_valid_pulse, 1);
    chk("drop_result", out_tog, 8'hDE);
    chk("drop_in_fin", out_drop_pulse, 1);
    vcnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clock);
      #1;
      if (out_tog_valid_pulse) vcnt++;
    end
    chk("drop_no_extra_valid", vcnt, 0);
    chk("drop_idle_busy", mod_busy, 0);
    last_out = 8'hDE;

    // Reset while in ADD abandons the op.
    @(negedge clock);
    in_tog = 8'h44; in_mode = 2'b01; in_tog_valid_pulse = 1'b1;
    @(posedge clock);
    #1 in_tog_valid_pulse = 1'b0;
    @(posedge clock);
    @(negedge clock) reset = 1'b1;
    @(posedge clock);
    #1;
    chk("midrst_out_tog", out_tog, 0);
    chk("midrst_busy", mod_busy, 0);
    chk("midrst_ovf", out_ovf, 0);
    chk("midrst_valid", out_tog_valid_pulse, 0);
    @(negedge clock) reset = 1'b0;
    vcnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clock);
      #1;
      if (out_tog_valid_pulse) vcnt++;
    end
    chk("midrst_no_valid", vcnt, 0);
    last_out = 8'h00;
    run_op(2'b01, 8'h03);

    for (int n = 0; n < 40; n++) begin
      run_op(2'($urandom_range(0, 3)), 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
